// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, transfer sizes and request validation for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] XFER_B = 4'd1;
  localparam logic [3:0] XFER_H = 4'd2;
  localparam logic [3:0] XFER_W = 4'd4;
  localparam logic [3:0] XFER_D = 8'd8;
  // Range check is done in 65 bits so an address near 2^64 cannot wrap into range.
  function automatic logic req_error(input logic [63:0] addr, input logic [3:0] size,
                                     input logic we, input logic re, input logic [64:0] depth);
    logic bad_size, misaligned, out_of_range;
    bad_size = !(size inside {XFER_B, XFER_H, XFER_W, XFER_D});
    misaligned = (addr & (64'(size) - 64'd1)) != 64'd0;
    out_of_range = ({1'b0, addr} + 65'(size)) > depth;
    return bad_size | misaligned | out_of_range | (we == re);
  endfunction
endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: little-endian byte-lane storage with a sized write strobe and a 64-bit combinational read.
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 1024,
  localparam int AW = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_size,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);
  logic [7:0] r_mem [DEPTH_BYTES];
  always_ff @(posedge clk)
    for (int k = 0; k < 8; k++)
      if (i_we && 4'(k) < i_size) r_mem[i_addr + AW'(k)] <= i_wdata[8*k +: 8];
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < 8; k++)
      o_rdata[8*k +: 8] = 4'(k) < i_size ? r_mem[i_addr + AW'(k)] : 8'h00;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder for the MEM-stage port, stalling the pipeline while busy.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [63:0] write_data,
  input  logic [3:0]  xfer_size,
  output logic        resp_valid,
  output logic [63:0] read_data,
  output logic        error,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = $clog2(LATENCY + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [63:0] r_addr, r_wdata, r_read_data, w_arr_rd, w_rd;
  logic [3:0] r_size;
  logic r_we, r_re, r_error, w_accept, w_err, w_resp, w_commit;
  assign w_accept = r_state == IDLE && req_valid;
  assign w_err = req_error(r_addr, r_size, r_we, r_re, 65'(DEPTH_BYTES));
  assign w_rd = w_err ? '0 : w_arr_rd;
  // A reset landing on the RESP edge must suppress the store.
  assign w_commit = r_state == RESP && !reset && !w_err && r_we;
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (req_valid ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
             r_state == WAIT ? (r_cnt == CW'(1) ? RESP : WAIT) : IDLE;
  always_comb begin
    w_resp = r_state == RESP && !reset;
    resp_valid = w_resp;
    req_ready = r_state == IDLE && !reset;
    stall = r_state == WAIT && !reset;
    read_data = reset ? '0 : w_resp ? w_rd : r_read_data;
    error = reset ? 1'b0 : w_resp ? w_err : r_error;
  end
  always_ff @(posedge clk)
    if (w_accept) begin
      r_cnt <= CW'(LATENCY - 1);
      r_addr <= address;
      r_we <= write_enable;
      r_re <= read_enable;
      r_wdata <= write_data;
      r_size <= xfer_size;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - CW'(1);
    end
  always_ff @(posedge clk)
    if (reset) begin
      r_read_data <= '0;
      r_error <= 1'b0;
    end else if (r_state == RESP) begin
      r_read_data <= w_rd;
      r_error <= w_err;
    end
  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clk(clk),
    .i_we(w_commit),
    .i_addr(r_addr[AW-1:0]),
    .i_size(r_size),
    .i_wdata(r_wdata),
    .o_rdata(w_arr_rd)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors for the responder at LATENCY=3 plus a LATENCY=1 instance.
module tb_dmem_responder;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic req_valid, req_ready, write_enable, read_enable, resp_valid, error, stall;
  logic [63:0] address, write_data, read_data;
  logic [3:0] xfer_size;
  logic l1_valid, l1_ready, l1_we, l1_re, l1_resp, l1_err, l1_stall;
  logic [63:0] l1_addr, l1_wdata, l1_rdata;
  logic [3:0] l1_size;
  int errors = 0, checks = 0, l1_stall_seen = 0;

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .write_enable(write_enable), .read_enable(read_enable),
    .write_data(write_data), .xfer_size(xfer_size), .resp_valid(resp_valid),
    .read_data(read_data), .error(error), .stall(stall));

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(l1_valid), .req_ready(l1_ready),
    .address(l1_addr), .write_enable(l1_we), .read_enable(l1_re),
    .write_data(l1_wdata), .xfer_size(l1_size), .resp_valid(l1_resp),
    .read_data(l1_rdata), .error(l1_err), .stall(l1_stall));

  always @(negedge clk) if (l1_stall) l1_stall_seen++;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic req(input logic we_i, input logic re_i, input logic [63:0] a, input logic [3:0] sz,
                     input logic [63:0] wd, output logic [63:0] rd, output logic e);
    int n, st;
    @(negedge clk);
    write_enable = we_i; read_enable = re_i; address = a; xfer_size = sz; write_data = wd;
    req_valid = 1'b1;
    chk("ready_idle", 64'(req_ready), 64'd1);
    n = 0; st = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      address = {$urandom, $urandom}; write_data = {$urandom, $urandom};
      write_enable = ~we_i; xfer_size = 4'(3);
      n++;
      if (stall) st++;
    end while (!resp_valid && n < 10);
    chk("latency", 64'(n), 64'd3);
    chk("stall_cycles", 64'(st), 64'd2);
    rd = read_data; e = error;
    @(negedge clk);
    chk("resp_pulse", 64'(resp_valid), 64'd0);
    chk("hold_rd", read_data, rd);
    chk("hold_err", 64'(error), 64'(e));
  endtask

  typedef struct {
    logic we, re;
    logic [63:0] addr;
    logic [3:0] size;
    logic [63:0] wd;
    logic err, chk_rd;
    logic [63:0] rd;
  } vec_t;
  vec_t tbl[17];

  logic [63:0] rd, rds[2];
  logic e, seen;
  int nr, rcyc[2];

  initial begin
    req_valid = 0; write_enable = 0; read_enable = 0; address = 0; write_data = 0; xfer_size = 0;
    l1_valid = 0; l1_we = 0; l1_re = 0; l1_addr = 0; l1_wdata = 0; l1_size = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp", 64'(resp_valid), 64'd0);
    chk("rst_rd", read_data, 64'd0);
    chk("rst_err", 64'(error), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    reset = 1'b0;
    #1 chk("post_rst_ready", 64'(req_ready), 64'd1);

    tbl[0]  = '{1, 0, 64'h10, 8, 64'h1122334455667788, 0, 0, 0};
    tbl[1]  = '{0, 1, 64'h10, 8, 0, 0, 1, 64'h1122334455667788};
    tbl[2]  = '{1, 0, 64'h13, 1, 64'hAB, 0, 0, 0};
    tbl[3]  = '{0, 1, 64'h10, 4, 0, 0, 1, 64'h00000000AB667788};
    tbl[4]  = '{0, 1, 64'h12, 2, 0, 0, 1, 64'h000000000000AB66};
    tbl[5]  = '{0, 1, 64'h11, 4, 0, 1, 1, 0};
    tbl[6]  = '{1, 0, 64'h3F8, 8, 64'hCAFEBABEDEADBEEF, 0, 0, 0};
    tbl[7]  = '{1, 0, 64'h3FC, 8, 64'hFFFFFFFFFFFFFFFF, 1, 1, 0};
    tbl[8]  = '{0, 1, 64'h3F8, 8, 0, 0, 1, 64'hCAFEBABEDEADBEEF};
    tbl[9]  = '{1, 1, 64'h10, 8, 0, 1, 1, 0};
    tbl[10] = '{1, 0, 64'h10, 3, 0, 1, 1, 0};
    tbl[11] = '{0, 0, 64'h10, 8, 0, 1, 1, 0};
    tbl[12] = '{1, 0, 64'h12, 4, 0, 1, 1, 0};
    tbl[13] = '{0, 1, 64'h10, 8, 0, 0, 1, 64'h11223344AB667788};
    tbl[14] = '{0, 1, 64'h17, 1, 0, 0, 1, 64'h11};
    tbl[15] = '{0, 1, 64'h100000010, 8, 0, 1, 1, 0};
    tbl[16] = '{1, 0, 64'h20, 1, 64'h00, 0, 0, 0};
    for (int i = 0; i < 17; i++) begin
      req(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].size, tbl[i].wd, rd, e);
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].err));
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
    end

    // Reset during WAIT drops a pending store.
    @(negedge clk);
    write_enable = 1; read_enable = 0; address = 64'h20; xfer_size = 1; write_data = 64'hFF; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    chk("mid_wait_stall", 64'(stall), 64'd1);
    reset = 1'b1;
    #1 chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("mid_post_ready", 64'(req_ready), 64'd1);
    chk("mid_post_rd", read_data, 64'd0);
    chk("mid_post_err", 64'(error), 64'd0);
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= resp_valid; end
    chk("mid_no_resp", 64'(seen), 64'd0);

    // Reset coinciding with the RESP edge must not commit.
    write_enable = 1; read_enable = 0; address = 64'h20; xfer_size = 1; write_data = 64'hEE; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("resp_rst_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    req(0, 1, 64'h20, 1, 0, rd, e);
    chk("rst_no_commit_rd", rd, 64'h00);
    chk("rst_no_commit_err", 64'(e), 64'd0);

    // Back-to-back with req_valid held high; the WAIT-time input change only affects the next accept.
    @(negedge clk);
    write_enable = 0; read_enable = 1; address = 64'h10; xfer_size = 8; req_valid = 1;
    chk("b2b_ready0", 64'(req_ready), 64'd1);
    nr = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin address = 64'h17; xfer_size = 1; end
      chk($sformatf("b2b_ready_c%0d", c), 64'(req_ready), 64'(c == 4 || c == 8));
      if (resp_valid) begin
        if (nr < 2) begin rds[nr] = read_data; rcyc[nr] = c; end
        nr++;
      end
      if (c == 8) req_valid = 0;
    end
    chk("b2b_nresp", 64'(nr), 64'd2);
    chk("b2b_cyc0", 64'(rcyc[0]), 64'd3);
    chk("b2b_cyc1", 64'(rcyc[1]), 64'd7);
    chk("b2b_rd0", rds[0], 64'h11223344AB667788);
    chk("b2b_rd1", rds[1], 64'h11);

    // LATENCY=1 instance.
    @(negedge clk);
    l1_we = 1; l1_re = 0; l1_addr = 0; l1_size = 8; l1_wdata = 64'h0123456789ABCDEF; l1_valid = 1;
    chk("l1_ready", 64'(l1_ready), 64'd1);
    @(negedge clk);
    l1_valid = 0;
    chk("l1_st_resp", 64'(l1_resp), 64'd1);
    chk("l1_st_err", 64'(l1_err), 64'd0);
    @(negedge clk);
    chk("l1_st_pulse", 64'(l1_resp), 64'd0);
    chk("l1_ready2", 64'(l1_ready), 64'd1);
    l1_we = 0; l1_re = 1; l1_valid = 1;
    @(negedge clk);
    l1_valid = 0;
    chk("l1_ld_resp", 64'(l1_resp), 64'd1);
    chk("l1_ld_rd", l1_rdata, 64'h0123456789ABCDEF);
    @(negedge clk);
    chk("l1_ld_pulse", 64'(l1_resp), 64'd0);
    chk("l1_no_stall", 64'(l1_stall_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
